pc_redirect_ctrl: RTL and testbench

PC_REDIRECT_CTRL -- requirements
Module: pc_redirect_ctrl

---
 rtl/pc_redirect_ctrl_pkg.sv | 33 +++
 rtl/pc_target_calc.sv | 45 ++++
 rtl/pc_redirect_ctrl.sv | 117 +++++++++++
 tb/tb_pc_redirect_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_redirect_ctrl_pkg.sv
// Shared types and defaults for the fetch PC redirect controller.
// Holds the FSM states, the redirect kinds and the reset/exception PCs.
package pc_redirect_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        PEND  = 2'd1,
        FLUSH = 2'd2
    } stateT;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        BR   = 2'd1,
        J    = 2'd2,
        JR   = 2'd3
    } redirKindT;

    localparam logic [31:0] DefResetPc   = 32'h0000_0000;
    localparam logic [31:0] DefExcVector = 32'h8000_0180;

    // Register jumps beat direct jumps, which beat branches.
    function automatic redirKindT pickKind(
        input logic jr,
        input logic j,
        input logic br
    );
        if (jr) return JR;
        if (j)  return J;
        if (br) return BR;
        return NONE;
    endfunction

endpackage

// File: rtl/pc_target_calc.sv
// Combinational redirect target selection and address arithmetic.
// Reports the winning request kind and a misaligned register-jump flag.
module pc_target_calc
    import pc_redirect_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = DefExcVector
) (
    input  logic [31:0] BasePC,
    input  logic        BranchTaken,
    input  logic [15:0] BranchOffset,
    input  logic        Jump,
    input  logic [25:0] JumpIndex,
    input  logic        JumpReg,
    input  logic [31:0] RegTarget,
    output logic [1:0]  reqKind,
    output logic [31:0] target,
    output logic        misalign
);

    redirKindT kind;
    logic [31:0] brOffset;

    assign brOffset = {{14{BranchOffset[15]}}, BranchOffset, 2'b00};
    assign reqKind  = kind;

    always_comb begin
        kind     = pickKind(JumpReg, Jump, BranchTaken);
        target   = '0;
        misalign = 1'b0;
        unique case (kind)
            JR: begin
                if (RegTarget[1:0] == 2'b00) begin
                    target = RegTarget;
                end else begin
                    target   = EXC_VECTOR;
                    misalign = 1'b1;
                end
            end
            J:       target = {BasePC[31:28], JumpIndex, 2'b00};
            BR:      target = BasePC + brOffset;
            default: target = '0;
        endcase
    end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Fetch PC register with branch/jump redirects, stall buffering and
// a one-cycle flush pulse after every applied redirect.
module pc_redirect_ctrl
    import pc_redirect_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DefResetPc,
    parameter logic [31:0] EXC_VECTOR = DefExcVector
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Stall,
    input  logic [31:0] BasePC,
    input  logic        BranchTaken,
    input  logic [15:0] BranchOffset,
    input  logic        Jump,
    input  logic [25:0] JumpIndex,
    input  logic        JumpReg,
    input  logic [31:0] RegTarget,
    output logic [31:0] PCOut,
    output logic [31:0] PCPlus4,
    output logic        Flush,
    output logic        AlignErr
);

    stateT       state, stateNext;
    logic [31:0] pcQ, pcNext;
    logic [31:0] pendTarget, pendTargetNext;
    logic        pendErr, pendErrNext;
    logic        flushQ, flushNext;
    logic        alignQ, alignNext;

    logic [1:0]  reqKind;
    logic [31:0] target;
    logic        misalign;
    logic        hasReq;

    pc_target_calc #(
        .EXC_VECTOR(EXC_VECTOR)
    ) u_calc (
        .BasePC      (BasePC),
        .BranchTaken (BranchTaken),
        .BranchOffset(BranchOffset),
        .Jump        (Jump),
        .JumpIndex   (JumpIndex),
        .JumpReg     (JumpReg),
        .RegTarget   (RegTarget),
        .reqKind     (reqKind),
        .target      (target),
        .misalign    (misalign)
    );

    assign hasReq   = (reqKind != NONE);
    assign PCOut    = pcQ;
    assign PCPlus4  = pcQ + 32'd4;
    assign Flush    = flushQ;
    assign AlignErr = alignQ;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state      <= RUN;
            pcQ        <= RESET_PC;
            pendTarget <= '0;
            pendErr    <= 1'b0;
            flushQ     <= 1'b0;
            alignQ     <= 1'b0;
        end else begin
            state      <= stateNext;
            pcQ        <= pcNext;
            pendTarget <= pendTargetNext;
            pendErr    <= pendErrNext;
            flushQ     <= flushNext;
            alignQ     <= alignNext;
        end
    end

    always_comb begin
        stateNext      = state;
        pcNext         = pcQ;
        pendTargetNext = pendTarget;
        pendErrNext    = pendErr;
        flushNext      = 1'b0;
        alignNext      = 1'b0;
        unique case (state)
            RUN: begin
                if (hasReq && Stall) begin
                    pendTargetNext = target;
                    pendErrNext    = misalign;
                    stateNext      = PEND;
                end else if (hasReq) begin
                    pcNext    = target;
                    flushNext = 1'b1;
                    alignNext = misalign;
                    stateNext = FLUSH;
                end else if (!Stall) begin
                    pcNext = PCPlus4;
                end
            end
            // First latched redirect wins; new requests are dropped.
            PEND: begin
                if (!Stall) begin
                    pcNext         = pendTarget;
                    flushNext      = 1'b1;
                    alignNext      = pendErr;
                    pendTargetNext = '0;
                    pendErrNext    = 1'b0;
                    stateNext      = FLUSH;
                end
            end
            FLUSH: begin
                if (!Stall) pcNext = PCPlus4;
                stateNext = RUN;
            end
            default: stateNext = RUN;
        endcase
    end

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Self-checking bench: directed vector table, reset corner cases and
// randomized traffic against a queue-based reference model.
module tb_pc_redirect_ctrl;

    localparam logic [31:0] ResetPc = 32'h0000_0000;
    localparam logic [31:0] ExcVec  = 32'h8000_0180;

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic        Stall = 1'b0;
    logic [31:0] BasePC = '0;
    logic        BranchTaken = 1'b0;
    logic [15:0] BranchOffset = '0;
    logic        Jump = 1'b0;
    logic [25:0] JumpIndex = '0;
    logic        JumpReg = 1'b0;
    logic [31:0] RegTarget = '0;
    logic [31:0] PCOut, PCPlus4;
    logic        Flush, AlignErr;

    int checks = 0;
    int failures = 0;

    pc_redirect_ctrl #(
        .RESET_PC  (ResetPc),
        .EXC_VECTOR(ExcVec)
    ) dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .Stall       (Stall),
        .BasePC      (BasePC),
        .BranchTaken (BranchTaken),
        .BranchOffset(BranchOffset),
        .Jump        (Jump),
        .JumpIndex   (JumpIndex),
        .JumpReg     (JumpReg),
        .RegTarget   (RegTarget),
        .PCOut       (PCOut),
        .PCPlus4     (PCPlus4),
        .Flush       (Flush),
        .AlignErr    (AlignErr)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic        stall;
        logic        br;
        logic [15:0] off;
        logic        j;
        logic [25:0] idx;
        logic        jr;
        logic [31:0] rt;
        logic [31:0] base;
        logic [31:0] expPc;
        logic        expFlush;
        logic        expAlign;
    } vecT;

    typedef struct {
        logic [31:0] t;
        logic        e;
    } pendT;

    vecT  tbl[$];
    pendT pendQ[$];
    logic [31:0] mPc;
    logic        mFlush, mAlign;

    function automatic vecT mk(
        input logic stall, input logic br, input logic [15:0] off,
        input logic j, input logic [25:0] idx,
        input logic jr, input logic [31:0] rt, input logic [31:0] base,
        input logic [31:0] pc, input logic f, input logic a
    );
        vecT v;
        v.stall = stall; v.br = br; v.off = off; v.j = j; v.idx = idx;
        v.jr = jr; v.rt = rt; v.base = base;
        v.expPc = pc; v.expFlush = f; v.expAlign = a;
        return v;
    endfunction

    function automatic vecT idle(input logic [31:0] pc);
        return mk(0, 0, 0, 0, 0, 0, 0, 0, pc, 0, 0);
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        mPc = ResetPc;
        mFlush = 1'b0;
        mAlign = 1'b0;
        pendQ.delete();
    endtask

    // Reference model: one step from the sampled inputs.
    task automatic modelStep();
        logic        req, err;
        logic [31:0] t;
        longint      off;
        pendT        p;
        req = JumpReg || Jump || BranchTaken;
        err = 1'b0;
        if (JumpReg) begin
            if (RegTarget % 4 == 0) t = RegTarget;
            else begin t = ExcVec; err = 1'b1; end
        end else if (Jump) begin
            t = (BasePC & 32'hF000_0000) | (32'(JumpIndex) * 4);
        end else begin
            off = longint'($signed(BranchOffset)) * 4;
            t = 32'(longint'(BasePC) + off);
        end
        if (mFlush) begin
            if (!Stall) mPc = mPc + 4;
            mFlush = 1'b0;
            mAlign = 1'b0;
        end else if (pendQ.size() > 0) begin
            if (!Stall) begin
                p = pendQ.pop_front();
                mPc = p.t;
                mFlush = 1'b1;
                mAlign = p.e;
            end
        end else if (req) begin
            if (Stall) begin
                p.t = t; p.e = err;
                pendQ.push_back(p);
            end else begin
                mPc = t;
                mFlush = 1'b1;
                mAlign = err;
            end
        end else if (!Stall) begin
            mPc = mPc + 4;
        end
    endtask

    task automatic apply(input vecT v);
        Stall = v.stall; BranchTaken = v.br; BranchOffset = v.off;
        Jump = v.j; JumpIndex = v.idx; JumpReg = v.jr;
        RegTarget = v.rt; BasePC = v.base;
    endtask

    task automatic tick();
        @(posedge Clk);
        modelStep();
        #1;
    endtask

    task automatic checkModel(input string tag);
        chk({tag, "_pc"}, PCOut, mPc);
        chk({tag, "_pc4"}, PCPlus4, mPc + 32'd4);
        chk({tag, "_flush"}, {31'd0, Flush}, {31'd0, mFlush});
        chk({tag, "_align"}, {31'd0, AlignErr}, {31'd0, mAlign});
    endtask

    initial begin
        tbl.push_back(idle(32'h4));
        tbl.push_back(idle(32'h8));
        tbl.push_back(idle(32'hC));
        tbl.push_back(mk(0, 0, 0, 1, 26'h100, 0, 0, 32'h1000_0010,
                         32'h1000_0400, 1, 0));
        tbl.push_back(idle(32'h1000_0404));
        tbl.push_back(mk(0, 1, 16'hFFFE, 1, 26'h100, 0, 0, 32'h200,
                         32'h400, 1, 0));
        tbl.push_back(idle(32'h404));
        tbl.push_back(mk(0, 1, 16'hFFFE, 0, 0, 0, 0, 32'h200,
                         32'h1F8, 1, 0));
        tbl.push_back(idle(32'h1FC));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 32'h1002, 0, ExcVec, 1, 1));
        tbl.push_back(idle(32'h8000_0184));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC, 0,
                         32'hFFFF_FFFC, 1, 0));
        tbl.push_back(idle(32'h0));
        tbl.push_back(mk(1, 1, 16'h0, 0, 0, 0, 0, 32'h40, 32'h0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 1, 26'h20, 0, 0, 32'h0, 32'h0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0));
        tbl.push_back(idle(32'h40));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h44, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 26'h40, 0, 0, 0, 32'h100, 1, 0));
        tbl.push_back(mk(1, 1, 16'h10, 0, 0, 0, 0, 0, 32'h100, 0, 0));
        tbl.push_back(idle(32'h104));
        tbl[16].expPc = 32'h0;
        tbl[17].expFlush = 1'b1;

        Rst = 1'b1;
        modelReset();
        #12;
        chk("reset_pc", PCOut, ResetPc);
        chk("reset_flush", {31'd0, Flush}, 32'd0);
        chk("reset_align", {31'd0, AlignErr}, 32'd0);
        @(negedge Clk);
        Rst = 1'b0;

        foreach (tbl[i]) begin
            apply(tbl[i]);
            tick();
            chk($sformatf("vec%0d_pc", i), PCOut, tbl[i].expPc);
            chk($sformatf("vec%0d_flush", i), {31'd0, Flush},
                {31'd0, tbl[i].expFlush});
            chk($sformatf("vec%0d_align", i), {31'd0, AlignErr},
                {31'd0, tbl[i].expAlign});
        end

        // Async reset while a redirect is pending.
        apply(mk(1, 1, 16'h4, 0, 0, 0, 0, 32'h1000, 0, 0, 0));
        tick();
        chk("pend_hold", PCOut, 32'h104);
        #2 Rst = 1'b1;
        #1;
        modelReset();
        chk("rstpend_pc", PCOut, ResetPc);
        chk("rstpend_flush", {31'd0, Flush}, 32'd0);
        #1 Rst = 1'b0;
        apply(idle(0));
        tick();
        chk("rstpend_after", PCOut, ResetPc + 32'd4);
        chk("rstpend_noflush", {31'd0, Flush}, 32'd0);

        // Async reset during the flush cycle.
        apply(mk(0, 0, 0, 1, 26'h40, 0, 0, 0, 0, 0, 0));
        tick();
        chk("preflush_pc", PCOut, 32'h100);
        #2 Rst = 1'b1;
        #1;
        modelReset();
        chk("rstflush_pc", PCOut, ResetPc);
        chk("rstflush_flush", {31'd0, Flush}, 32'd0);
        #1 Rst = 1'b0;
        apply(idle(0));
        tick();
        chk("rstflush_after", PCOut, ResetPc + 32'd4);

        for (int n = 0; n < 3000; n++) begin
            Stall        = ($urandom % 4) == 0;
            BranchTaken  = ($urandom % 5) == 0;
            Jump         = ($urandom % 8) == 0;
            JumpReg      = ($urandom % 8) == 0;
            BasePC       = $urandom;
            BranchOffset = 16'($urandom);
            JumpIndex    = 26'($urandom);
            RegTarget    = $urandom;
            if ($urandom % 2 == 0) RegTarget[1:0] = 2'b00;
            if ($urandom % 600 == 0) begin
                #2 Rst = 1'b1;
                #1;
                modelReset();
                chk("rnd_rst_pc", PCOut, ResetPc);
                #1 Rst = 1'b0;
            end
            tick();
            checkModel("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
